axis_blender_sched: RTL and testbench
=====================================

Name: axis_blender_sched

Overview:
- Frame-synchronous scheduler for the two-stream alpha blender. Sits beside the blender and drives its s1_enable.
- Snoops the blender's master-side handshake to track row/column position against the configured geometry.
- Applies software overlay requests only at frame boundaries, optionally for a bounded number of frames.
- Reports frame count and sticky geometry errors.

Parameters:
C_IMG_BITS, 12, width of geometry and position counters
C_FRAME_BITS, 8, width of frame budget and frame counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cfg_width  input  C_IMG_BITS  pixels per row, >=1; sampled on ctl_start
cfg_height  input  C_IMG_BITS  rows per frame, >=1; sampled on ctl_start
ctl_start  input  1  pulse: IDLE->SYNC
ctl_stop  input  1  pulse: stop at next frame end
req_valid  input  1  pulse: new overlay request
req_s1_en  input  1  requested s1_enable value
req_frames  input  C_FRAME_BITS  frames to keep enable=1; 0 = unlimited
mon_valid  input  1  blender m_axis_tvalid
mon_ready  input  1  blender m_axis_tready
mon_user  input  1  blender m_axis_tuser[0] (start of frame)
mon_last  input  1  blender m_axis_tlast
s1_enable  output  1  registered enable to blender
busy  output  1  state != IDLE
frame_cnt  output  C_FRAME_BITS  completed frames in ACTIVE; wraps
err_width  output  1  sticky: tlast/column mismatch
err_height  output  1  sticky: SOF arrived mid-frame

Behaviour:
- Reset values: s1_enable=0, busy=0, frame_cnt=0, err_*=0, state=IDLE, row=col=0, pending=0, remaining=0, stop_pending=0.
- Beat: mon_valid & mon_ready. Non-beat cycles never change counters.
- States:
  - IDLE: ctl_start latches width/height and goes to SYNC. ctl_start is ignored in SYNC/ACTIVE.
  - SYNC: waits for a beat with mon_user=1, then goes to ACTIVE; that beat is counted as row 0, col 0.
  - ACTIVE: tracks the frame.
- Position: col = index of next beat in the row.
  - Beat with col==width-1: col<=0, row<=row+1.
  - Frame end = beat with col==width-1 and row==height-1: row<=0, col<=0.
- Errors:
  - err_width sets when mon_last != (col==width-1) on any ACTIVE beat. Counting follows col, not mon_last.
  - err_height sets on an ACTIVE beat with mon_user=1 while (row,col) != (0,0). Counters resync: the beat is treated as row 0, col 0.
  - Errors clear only on reset.
- Requests:
  - In IDLE/SYNC: applied the cycle after req_valid. s1_enable<=req_s1_en, remaining<=req_frames.
  - In ACTIVE: stored in a single pending slot; a later request overwrites it. Applied at the next frame end, so s1_enable changes the cycle after the final beat.
  - req_valid coincident with frame end: the new request is applied directly and the old pending is discarded.
- Budget (ACTIVE frame end with no pending):
  - If s1_enable=1 and remaining>0: remaining<=remaining-1.
  - Decrement from 1 also drives s1_enable<=0.
  - remaining=0 means unlimited.
- frame_cnt increments on every ACTIVE frame end.
- Stop:
  - ctl_stop in ACTIVE sets stop_pending. At frame end: state<=IDLE, s1_enable<=0, pending dropped.
  - ctl_stop in SYNC: immediate IDLE, s1_enable<=0.
  - Ignored in IDLE.
  - Stop and request at the same frame end: stop wins.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset mid-frame: all state clears immediately. The next frame requires ctl_start again.

Test Plan:
- Nominal tracking: width=3, height=5, start, one request (req_s1_en=1, frames=0) in SYNC, 3 frames of randomized handshakes -> s1_enable=1 one cycle after req; frame_cnt=3; errors 0.
- Boundary deferral: in ACTIVE, request enable=0 at row 2 col 1 -> s1_enable stays 1 through the 15th beat, drops exactly one cycle after it.
- Budget: request enable=1, frames=2 in SYNC -> s1_enable=1 for two full frames, 0 after the 2nd frame end; frame_cnt=2.
- Coincident events: req_valid(enable=0) and ctl_stop on the same cycle as the final beat -> IDLE, s1_enable=0, busy=0 next cycle.
- Errors: mon_last on col 1 of a width-3 row -> err_width=1; SOF at row 3 -> err_height=1; counters resync to (0,1) after that beat; both stay set.
- Async reset: assert reset mid-frame between clock edges -> all outputs 0 immediately; beats ignored until ctl_start plus SOF.

Source files
------------

// File: rtl/axis_blender_sched.sv
// Frame-synchronous scheduler for the two-stream alpha blender: snoops the master-side handshake,
// tracks row/column position and applies overlay enable requests only at frame boundaries.
module axis_blender_sched #(
  parameter int unsigned C_IMG_BITS   = 12,
  parameter int unsigned C_FRAME_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [C_IMG_BITS-1:0]   cfg_width,
  input  logic [C_IMG_BITS-1:0]   cfg_height,
  input  logic                    ctl_start,
  input  logic                    ctl_stop,
  input  logic                    req_valid,
  input  logic                    req_s1_en,
  input  logic [C_FRAME_BITS-1:0] req_frames,
  input  logic                    mon_valid,
  input  logic                    mon_ready,
  input  logic                    mon_user,
  input  logic                    mon_last,
  output logic                    s1_enable,
  output logic                    busy,
  output logic [C_FRAME_BITS-1:0] frame_cnt,
  output logic                    err_width,
  output logic                    err_height
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSync   = 2'd1;
  localparam logic [1:0] StActive = 2'd2;

  localparam logic [C_IMG_BITS-1:0]   ImgOne   = {{(C_IMG_BITS-1){1'b0}}, 1'b1};
  localparam logic [C_FRAME_BITS-1:0] FrameOne = {{(C_FRAME_BITS-1){1'b0}}, 1'b1};

  logic [1:0]              state_q, state_d;
  logic [C_IMG_BITS-1:0]   width_q, width_d;
  logic [C_IMG_BITS-1:0]   height_q, height_d;
  logic [C_IMG_BITS-1:0]   row_q, row_d;
  logic [C_IMG_BITS-1:0]   col_q, col_d;
  logic                    pend_q, pend_d;
  logic                    pend_en_q, pend_en_d;
  logic [C_FRAME_BITS-1:0] pend_frames_q, pend_frames_d;
  logic [C_FRAME_BITS-1:0] remaining_q, remaining_d;
  logic                    stop_q, stop_d;
  logic                    s1_q, s1_d;
  logic [C_FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic                    err_width_q, err_width_d;
  logic                    err_height_q, err_height_d;

  logic                  beat;
  logic                  sof_resync;
  logic [C_IMG_BITS-1:0] row_eff, col_eff;
  logic [C_IMG_BITS-1:0] row_nxt, col_nxt;
  logic                  last_col, last_row;
  logic                  frame_end;

  // A SOF beat is always position (0,0): in SYNC the counters are already zero, and in ACTIVE a
  // mid-frame SOF resynchronises the counters onto it.
  always_comb begin
    beat       = mon_valid & mon_ready;
    sof_resync = (state_q == StActive) && mon_user && ((row_q != '0) || (col_q != '0));
    row_eff    = mon_user ? '0 : row_q;
    col_eff    = mon_user ? '0 : col_q;
    last_col   = (col_eff == (width_q - ImgOne));
    last_row   = (row_eff == (height_q - ImgOne));
    frame_end  = (state_q == StActive) && beat && last_col && last_row;
    col_nxt    = last_col ? '0 : col_eff + ImgOne;
    if (!last_col) begin
      row_nxt = row_eff;
    end else if (last_row) begin
      row_nxt = '0;
    end else begin
      row_nxt = row_eff + ImgOne;
    end
  end

  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    height_d      = height_q;
    row_d         = row_q;
    col_d         = col_q;
    pend_d        = pend_q;
    pend_en_d     = pend_en_q;
    pend_frames_d = pend_frames_q;
    remaining_d   = remaining_q;
    stop_d        = stop_q;
    s1_d          = s1_q;
    frame_cnt_d   = frame_cnt_q;
    err_width_d   = err_width_q;
    err_height_d  = err_height_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          s1_d        = req_s1_en;
          remaining_d = req_frames;
        end
        if (ctl_start) begin
          width_d  = cfg_width;
          height_d = cfg_height;
          row_d    = '0;
          col_d    = '0;
          stop_d   = 1'b0;
          state_d  = StSync;
        end
      end

      StSync: begin
        if (ctl_stop) begin
          state_d = StIdle;
          s1_d    = 1'b0;
        end else begin
          if (req_valid) begin
            s1_d        = req_s1_en;
            remaining_d = req_frames;
          end
          if (beat && mon_user) begin
            row_d   = row_nxt;
            col_d   = col_nxt;
            state_d = StActive;
          end
        end
      end

      StActive: begin
        if (beat) begin
          row_d = row_nxt;
          col_d = col_nxt;
          if (mon_last != last_col) err_width_d = 1'b1;
          if (sof_resync) err_height_d = 1'b1;
        end
        if (frame_end) begin
          frame_cnt_d = frame_cnt_q + FrameOne;
          if (stop_q || ctl_stop) begin
            state_d = StIdle;
            s1_d    = 1'b0;
            pend_d  = 1'b0;
            stop_d  = 1'b0;
            row_d   = '0;
            col_d   = '0;
          end else if (req_valid) begin
            s1_d        = req_s1_en;
            remaining_d = req_frames;
            pend_d      = 1'b0;
          end else if (pend_q) begin
            s1_d        = pend_en_q;
            remaining_d = pend_frames_q;
            pend_d      = 1'b0;
          end else if (s1_q && (remaining_q != '0)) begin
            // Zero budget means unlimited; the last budgeted frame turns the overlay off.
            remaining_d = remaining_q - FrameOne;
            if (remaining_q == FrameOne) s1_d = 1'b0;
          end
        end else begin
          if (req_valid) begin
            pend_d        = 1'b1;
            pend_en_d     = req_s1_en;
            pend_frames_d = req_frames;
          end
          if (ctl_stop) stop_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      width_q       <= '0;
      height_q      <= '0;
      row_q         <= '0;
      col_q         <= '0;
      pend_q        <= 1'b0;
      pend_en_q     <= 1'b0;
      pend_frames_q <= '0;
      remaining_q   <= '0;
      stop_q        <= 1'b0;
      s1_q          <= 1'b0;
      frame_cnt_q   <= '0;
      err_width_q   <= 1'b0;
      err_height_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      height_q      <= height_d;
      row_q         <= row_d;
      col_q         <= col_d;
      pend_q        <= pend_d;
      pend_en_q     <= pend_en_d;
      pend_frames_q <= pend_frames_d;
      remaining_q   <= remaining_d;
      stop_q        <= stop_d;
      s1_q          <= s1_d;
      frame_cnt_q   <= frame_cnt_d;
      err_width_q   <= err_width_d;
      err_height_q  <= err_height_d;
    end
  end

  assign s1_enable  = s1_q;
  assign busy       = (state_q != StIdle);
  assign frame_cnt  = frame_cnt_q;
  assign err_width  = err_width_q;
  assign err_height = err_height_q;

endmodule

// File: tb/tb_axis_blender_sched.sv
// Bench for axis_blender_sched: directed scenarios, an error-vector table and randomized traffic,
// all cross-checked every cycle against a pixel-index reference model.
module tb_axis_blender_sched;

  localparam int IB = 12;
  localparam int FB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [IB-1:0] cfg_width = '0;
  logic [IB-1:0] cfg_height = '0;
  logic          ctl_start = 1'b0;
  logic          ctl_stop = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_s1_en = 1'b0;
  logic [FB-1:0] req_frames = '0;
  logic          mon_valid = 1'b0;
  logic          mon_ready = 1'b0;
  logic          mon_user = 1'b0;
  logic          mon_last = 1'b0;
  logic          s1_enable;
  logic          busy;
  logic [FB-1:0] frame_cnt;
  logic          err_width;
  logic          err_height;

  always #5 clk = ~clk;

  axis_blender_sched #(.C_IMG_BITS(IB), .C_FRAME_BITS(FB)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .ctl_start  (ctl_start),
    .ctl_stop   (ctl_stop),
    .req_valid  (req_valid),
    .req_s1_en  (req_s1_en),
    .req_frames (req_frames),
    .mon_valid  (mon_valid),
    .mon_ready  (mon_ready),
    .mon_user   (mon_user),
    .mon_last   (mon_last),
    .s1_enable  (s1_enable),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .err_width  (err_width),
    .err_height (err_height)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: position is a single pixel index within the frame (0 .. w*h-1).
  int m_state, m_w, m_h, m_p, m_s1, m_rem, m_pend, m_pend_en, m_pend_fr, m_stop, m_fc, m_ew, m_eh;

  task automatic m_reset();
    m_state = 0; m_w = 0; m_h = 0; m_p = 0; m_s1 = 0; m_rem = 0; m_pend = 0;
    m_pend_en = 0; m_pend_fr = 0; m_stop = 0; m_fc = 0; m_ew = 0; m_eh = 0;
  endtask

  task automatic m_step();
    bit b;
    bit fe;
    b = mon_valid && mon_ready;
    fe = 0;
    case (m_state)
      0: begin
        if (req_valid) begin m_s1 = req_s1_en; m_rem = req_frames; end
        if (ctl_start) begin
          m_w = cfg_width; m_h = cfg_height; m_p = 0; m_stop = 0; m_state = 1;
        end
      end
      1: begin
        if (ctl_stop) begin
          m_state = 0; m_s1 = 0;
        end else begin
          if (req_valid) begin m_s1 = req_s1_en; m_rem = req_frames; end
          if (b && mon_user) begin
            m_state = 2;
            m_p = (m_w * m_h == 1) ? 0 : 1;
          end
        end
      end
      default: begin
        if (b) begin
          if (mon_user && m_p != 0) begin m_eh = 1; m_p = 0; end
          if (mon_last != ((m_p % m_w) == m_w - 1)) m_ew = 1;
          fe = (m_p == m_w * m_h - 1);
          m_p = fe ? 0 : m_p + 1;
        end
        if (fe) begin
          m_fc = (m_fc + 1) % 256;
          if (m_stop || ctl_stop) begin
            m_state = 0; m_s1 = 0; m_pend = 0; m_stop = 0; m_p = 0;
          end else if (req_valid) begin
            m_s1 = req_s1_en; m_rem = req_frames; m_pend = 0;
          end else if (m_pend) begin
            m_s1 = m_pend_en; m_rem = m_pend_fr; m_pend = 0;
          end else if (m_s1 && m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_s1 = 0;
          end
        end else begin
          if (req_valid) begin m_pend = 1; m_pend_en = req_s1_en; m_pend_fr = req_frames; end
          if (ctl_stop) m_stop = 1;
        end
      end
    endcase
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    chk("model s1_enable", s1_enable, m_s1);
    chk("model busy", busy, (m_state != 0) ? 1 : 0);
    chk("model frame_cnt", frame_cnt, m_fc);
    chk("model err_width", err_width, m_ew);
    chk("model err_height", err_height, m_eh);
    ctl_start = 0; ctl_stop = 0; req_valid = 0;
    mon_valid = 0; mon_ready = 0; mon_user = 0; mon_last = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic beat(input bit u, input bit l);
    mon_valid = 1; mon_ready = 1; mon_user = u; mon_last = l;
    tick();
  endtask

  // Well-formed beat at the model's current position.
  task automatic good_beat();
    bit l;
    l = (m_w > 0) ? ((m_p % m_w) == m_w - 1) : 1'b0;
    beat(m_p == 0, l);
  endtask

  task automatic stall();
    int k;
    k = $urandom_range(0, 2);
    mon_valid = (k == 0); mon_ready = (k == 1);
    mon_user = 1'($urandom); mon_last = 1'($urandom);
    tick();
  endtask

  task automatic start(input int w, input int h);
    cfg_width = IB'(w); cfg_height = IB'(h); ctl_start = 1;
    tick();
  endtask

  task automatic req(input bit en, input int fr);
    req_valid = 1; req_s1_en = en; req_frames = FB'(fr);
    tick();
  endtask

  typedef struct {
    bit v, r, u, l;
    int ew, eh, fc;
  } vec_t;

  vec_t tv[27];

  function automatic vec_t mk(input bit v, r, u, l, input int ew, eh, fc);
    vec_t t;
    t.v = v; t.r = r; t.u = u; t.l = l; t.ew = ew; t.eh = eh; t.fc = fc;
    return t;
  endfunction

  initial begin
    // Width-3, height-5 frame: bad tlast at col 1, SOF at row 3 col 1, then the 14 beats that
    // complete a frame counted from the resynchronised position (0,1).
    tv[0]  = mk(1, 1, 1, 0, 0, 0, 0);
    tv[1]  = mk(1, 1, 0, 1, 1, 0, 0);
    tv[2]  = mk(1, 0, 1, 1, 1, 0, 0);
    tv[3]  = mk(1, 1, 0, 1, 1, 0, 0);
    tv[4]  = mk(1, 1, 0, 0, 1, 0, 0);
    tv[5]  = mk(1, 1, 0, 0, 1, 0, 0);
    tv[6]  = mk(1, 1, 0, 1, 1, 0, 0);
    tv[7]  = mk(0, 1, 1, 0, 1, 0, 0);
    tv[8]  = mk(1, 1, 0, 0, 1, 0, 0);
    tv[9]  = mk(1, 1, 0, 0, 1, 0, 0);
    tv[10] = mk(1, 1, 0, 1, 1, 0, 0);
    tv[11] = mk(1, 1, 0, 0, 1, 0, 0);
    tv[12] = mk(1, 1, 1, 0, 1, 1, 0);
    for (int k = 0; k < 14; k++) begin
      tv[13 + k] = mk(1, 1, 0, ((1 + k) % 3) == 2, 1, 1, (k == 13) ? 1 : 0);
    end

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset s1_enable", s1_enable, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_cnt", frame_cnt, 0);
    chk("reset err_width", err_width, 0);
    chk("reset err_height", err_height, 0);
    reset = 0;

    // Nominal tracking and boundary deferral
    start(3, 5);
    chk("nominal busy after start", busy, 1);
    req(1, 0);
    chk("nominal s1 one cycle after req", s1_enable, 1);
    for (int k = 0; k < 45; k++) begin
      if ($urandom_range(0, 2) == 0) stall();
      good_beat();
    end
    chk("nominal frame_cnt", frame_cnt, 3);
    chk("nominal err_width", err_width, 0);
    chk("nominal err_height", err_height, 0);
    repeat (7) good_beat();
    req(0, 0);
    for (int b = 8; b <= 15; b++) begin
      good_beat();
      chk($sformatf("deferral s1 after beat %0d", b), s1_enable, (b == 15) ? 0 : 1);
    end
    chk("deferral frame_cnt", frame_cnt, 4);

    // Frame budget of two
    do_reset();
    start(3, 5);
    req(1, 2);
    chk("budget s1 after req", s1_enable, 1);
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 15; b++) begin
        good_beat();
        chk($sformatf("budget s1 f%0d b%0d", f, b), s1_enable, (f == 1 && b == 14) ? 0 : 1);
      end
    end
    chk("budget frame_cnt", frame_cnt, 2);
    for (int b = 0; b < 15; b++) good_beat();
    chk("budget s1 stays off", s1_enable, 0);

    // Stop and request coincident with the final beat
    do_reset();
    start(3, 5);
    req(1, 0);
    repeat (14) good_beat();
    req_valid = 1; req_s1_en = 0; req_frames = 0; ctl_stop = 1;
    good_beat();
    chk("coincident busy", busy, 0);
    chk("coincident s1", s1_enable, 0);
    chk("coincident frame_cnt", frame_cnt, 1);
    repeat (3) good_beat();
    chk("coincident stays idle", busy, 0);

    // Error vector table
    do_reset();
    start(3, 5);
    for (int i = 0; i < 27; i++) begin
      mon_valid = tv[i].v; mon_ready = tv[i].r; mon_user = tv[i].u; mon_last = tv[i].l;
      tick();
      chk($sformatf("vec%0d err_width", i), err_width, tv[i].ew);
      chk($sformatf("vec%0d err_height", i), err_height, tv[i].eh);
      chk($sformatf("vec%0d frame_cnt", i), frame_cnt, tv[i].fc);
    end

    // Asynchronous reset between clock edges
    do_reset();
    start(3, 5);
    req(1, 0);
    repeat (19) good_beat();
    chk("pre-reset frame_cnt", frame_cnt, 1);
    #3;
    reset = 1;
    m_reset();
    #1;
    chk("async reset s1", s1_enable, 0);
    chk("async reset busy", busy, 0);
    chk("async reset frame_cnt", frame_cnt, 0);
    @(posedge clk);
    #1;
    reset = 0;
    repeat (4) beat(1, 0);
    chk("post-reset beats ignored busy", busy, 0);
    chk("post-reset beats ignored frame_cnt", frame_cnt, 0);
    start(3, 5);
    beat(0, 0);
    chk("post-reset waits for SOF", busy, 1);
    repeat (15) good_beat();
    chk("post-reset frame after SOF", frame_cnt, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 6; c++) begin
      do_reset();
      start($urandom_range(1, 4), $urandom_range(1, 3));
      for (int n = 0; n < 300; n++) begin
        cfg_width  = IB'($urandom_range(1, 4));
        cfg_height = IB'($urandom_range(1, 3));
        ctl_start  = (m_state == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 49) == 0);
        ctl_stop   = ($urandom_range(0, 59) == 0);
        req_valid  = ($urandom_range(0, 14) == 0);
        req_s1_en  = 1'($urandom);
        req_frames = FB'($urandom_range(0, 3));
        mon_valid  = ($urandom_range(0, 3) != 0);
        mon_ready  = ($urandom_range(0, 3) != 0);
        if (m_state == 1) mon_user = ($urandom_range(0, 2) == 0);
        else mon_user = (m_p == 0) ^ ($urandom_range(0, 29) == 0);
        if (m_w > 0) mon_last = (((m_p % m_w) == m_w - 1)) ^ ($urandom_range(0, 29) == 0);
        else mon_last = 1'($urandom);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
